// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC generation, credit-limited imem requests, and a
// small {pc, instr} FIFO feeding decode, with redirect flush and stale-response drain.
//
//  state | meaning
//  RUN   | issuing requests, pushing responses into the FIFO
//  DRAIN | requests held off, dropping responses to pre-redirect fetches
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    input  logic        dec_ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   fifo_pc    [DEPTH];
    logic [31:0]   fifo_instr [DEPTH];

    logic [31:0]   redirect_target;
    logic [CW:0]   credit_used;
    logic [CW-1:0] stale_left;
    logic [CW-1:0] push_inc;
    logic [CW-1:0] pop_inc;
    logic [CW-1:0] fire_inc;
    logic [CW-1:0] rsp_inc;
    logic          rsp_ok;
    logic          push;
    logic          pop;
    logic          req_fire;

    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    assign dec_valid = !rst && (count != '0);
    assign dec_instr = dec_valid ? fifo_instr[rd_ptr] : 32'h0;
    assign dec_pc    = dec_valid ? fifo_pc[rd_ptr]    : 32'h0;
    assign pop       = dec_valid && dec_ready;

    // A pop this cycle frees its slot in time for a new request, which is what
    // lets a two-entry FIFO sustain one instruction per cycle with 1-cycle memory.
    assign credit_used = {1'b0, count} + {1'b0, inflight} - {{CW{1'b0}}, pop};

    assign imem_req_valid = !rst && (state == RUN) && !redirect_valid && (credit_used < DEPTH_W);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_ok     = imem_rsp_valid && (inflight != '0);
    assign push       = !rst && rsp_ok && (state == RUN) && !redirect_valid;
    assign push_inc   = {{(CW-1){1'b0}}, push};
    assign pop_inc    = {{(CW-1){1'b0}}, pop};
    assign fire_inc   = {{(CW-1){1'b0}}, req_fire};
    assign rsp_inc    = {{(CW-1){1'b0}}, rsp_ok};
    assign stale_left = inflight - rsp_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_target;
            rsp_pc   <= redirect_target;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            inflight <= stale_left;
            discard  <= stale_left;
            state    <= (stale_left != '0) ? DRAIN : RUN;
        end else begin
            count <= count + push_inc - pop_inc;
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                rsp_pc <= rsp_pc + 32'd4;
            end
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            unique case (state)
                RUN: begin
                    inflight <= inflight + fire_inc - rsp_inc;
                end
                DRAIN: begin
                    if (rsp_ok) begin
                        inflight <= inflight - CNT_ONE;
                        discard  <= discard - CNT_ONE;
                        if (discard == CNT_ONE) begin
                            state <= RUN;
                        end
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= rsp_pc;
            fifo_instr[wr_ptr] <= imem_rsp_data;
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(imem_rsp_valid && (inflight == '0)));
    assert property (@(posedge clk) disable iff (rst) !(push && !pop && (count == DEPTH_C)));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: latency-configurable memory model, scoreboard of
// expected decode PCs, and directed phases for stall, redirect and reset.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_ready      (dec_ready)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    int          checks   = 0;
    int          failures = 0;
    int          popped   = 0;
    int          cyc      = 0;
    int          mem_lat  = 1;
    logic [31:0] exp_q [$];
    mreq_t       mem_q [$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic expect_from(input logic [31:0] base);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    // memory: request accepted at edge N answers in cycle N+mem_lat
    always begin
        logic rst_at_edge;
        @(posedge clk);
        cyc = cyc + 1;
        rst_at_edge = rst;
        if (rst_at_edge) mem_q.delete();
        else if (imem_req_valid && imem_req_ready)
            mem_q.push_back('{imem_req_addr, cyc + mem_lat - 1});
        #1;
        if (!rst_at_edge && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    end

    // scoreboard monitor: pops squashed by a redirect never reach decode
    always begin
        logic [31:0] e;
        @(negedge clk);
        if (!rst && dec_valid && dec_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual_pc=%h required=none", dec_pc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", dec_pc, e);
                chk("sb_instr", dec_instr, instr_of(e));
                popped++;
            end
        end
    end

    initial begin
        int n;
        int bad;
        int p0;
        logic [31:0] cap_pc;
        logic [31:0] cap_instr;

        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        dec_ready = 1'b1; imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;

        // reset and streaming
        repeat (3) next_cycle();
        at_neg();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_dec_instr", dec_instr, 32'h0);
        chk("rst_dec_pc", dec_pc, 32'h0);
        next_cycle(); rst = 1'b0; expect_from(32'h100);
        at_neg();
        chk("start_req_valid", 32'(imem_req_valid), 32'd1);
        chk("start_req_addr", imem_req_addr, 32'h100);
        next_cycle(); at_neg();
        chk("lat_dec_valid_n1", 32'(dec_valid), 32'd0);
        next_cycle(); at_neg();
        chk("lat_dec_valid_n2", 32'(dec_valid), 32'd1);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            next_cycle(); at_neg();
            if (dec_valid) n++;
        end
        chk("throughput", 32'(n), 32'd8);

        // back-pressure
        next_cycle(); dec_ready = 1'b0;
        at_neg();
        cap_pc = dec_pc; cap_instr = dec_instr; bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin next_cycle(); at_neg(); end
            if (imem_req_valid !== 1'b0 || dec_valid !== 1'b1 ||
                dec_pc !== cap_pc || dec_instr !== cap_instr) bad++;
        end
        chk("bp_stall", 32'(bad), 32'd0);
        next_cycle(); dec_ready = 1'b1; p0 = popped;
        at_neg();
        for (int i = 0; i < 9; i++) begin next_cycle(); at_neg(); end
        next_cycle();
        chk("bp_resume_count", 32'(popped - p0), 32'd10);

        // redirect with two in flight, 3-cycle memory
        imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin at_neg(); next_cycle(); end
        mem_lat = 3; imem_req_ready = 1'b1;
        at_neg();
        next_cycle(); at_neg();
        next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h200; expect_from(32'h200);
        p0 = popped;
        at_neg();
        chk("rd1_req_blocked", 32'(imem_req_valid), 32'd0);
        next_cycle(); redirect_valid = 1'b0;
        at_neg();
        chk("rd1_drain_req", 32'(imem_req_valid), 32'd0);
        chk("rd1_stale_rsp0", 32'(imem_rsp_valid), 32'd1);
        chk("rd1_fifo_empty", 32'(dec_valid), 32'd0);
        next_cycle(); at_neg();
        chk("rd1_drain_req2", 32'(imem_req_valid), 32'd0);
        chk("rd1_stale_rsp1", 32'(imem_rsp_valid), 32'd1);
        next_cycle(); at_neg();
        chk("rd1_refetch_valid", 32'(imem_req_valid), 32'd1);
        chk("rd1_refetch_addr", imem_req_addr, 32'h200);
        for (int i = 0; i < 15; i++) begin next_cycle(); at_neg(); end
        next_cycle();
        chk("rd1_progress", 32'(popped - p0 > 0), 32'd1);

        // redirect coinciding with a response and a pop, misaligned target
        mem_lat = 1;
        for (int i = 0; i < 10; i++) begin at_neg(); next_cycle(); end
        redirect_valid = 1'b1; redirect_pc = 32'h303; expect_from(32'h300);
        p0 = popped;
        at_neg();
        chk("rd2_rsp_same_cycle", 32'(imem_rsp_valid), 32'd1);
        chk("rd2_pop_same_cycle", 32'(dec_valid), 32'd1);
        next_cycle(); redirect_valid = 1'b0;
        at_neg();
        chk("rd2_refetch_valid", 32'(imem_req_valid), 32'd1);
        chk("rd2_refetch_addr", imem_req_addr, 32'h300);
        chk("rd2_fifo_empty", 32'(dec_valid), 32'd0);
        for (int i = 0; i < 10; i++) begin next_cycle(); at_neg(); end
        next_cycle();
        chk("rd2_progress", 32'(popped - p0 > 0), 32'd1);

        // back-to-back redirects, second one during DRAIN
        imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin at_neg(); next_cycle(); end
        mem_lat = 3; imem_req_ready = 1'b1;
        at_neg();
        next_cycle(); at_neg();
        next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h400; exp_q.delete();
        at_neg();
        next_cycle(); redirect_pc = 32'h500; expect_from(32'h500);
        p0 = popped;
        at_neg();
        chk("rd3_stale_rsp0", 32'(imem_rsp_valid), 32'd1);
        next_cycle(); redirect_valid = 1'b0;
        at_neg();
        chk("rd3_drain_req", 32'(imem_req_valid), 32'd0);
        chk("rd3_stale_rsp1", 32'(imem_rsp_valid), 32'd1);
        next_cycle(); at_neg();
        chk("rd3_refetch_valid", 32'(imem_req_valid), 32'd1);
        chk("rd3_refetch_addr", imem_req_addr, 32'h500);
        for (int i = 0; i < 20; i++) begin next_cycle(); at_neg(); end
        next_cycle();
        chk("rd3_progress", 32'(popped - p0 > 0), 32'd1);

        // reset mid-stream with a full FIFO and a redirect
        mem_lat = 1;
        for (int i = 0; i < 8; i++) begin at_neg(); next_cycle(); end
        dec_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin at_neg(); next_cycle(); end
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h600; dec_ready = 1'b1;
        exp_q.delete();
        at_neg();
        chk("mrst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("mrst_dec_valid", 32'(dec_valid), 32'd0);
        chk("mrst_dec_instr", dec_instr, 32'h0);
        chk("mrst_dec_pc", dec_pc, 32'h0);
        next_cycle(); rst = 1'b0; redirect_valid = 1'b0; expect_from(32'h100);
        p0 = popped;
        at_neg();
        chk("mrst_after_dec_valid", 32'(dec_valid), 32'd0);
        chk("mrst_after_req_valid", 32'(imem_req_valid), 32'd1);
        chk("mrst_after_req_addr", imem_req_addr, 32'h100);
        for (int i = 0; i < 9; i++) begin next_cycle(); at_neg(); end
        next_cycle();
        chk("mrst_resume_count", 32'(popped - p0), 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
